// File: rtl/genesis_pad_pkg.sv
// Shared types and constants for the Genesis controller-port emulation.
//   pad_type_e : pad type code coming from genesis_gamepads
//   BTN_*      : bit positions inside the 12-bit decoded button word
//   phase_t    : 6-button TH phase counter
//   port_mux() : active-low 6-bit port word for a given type/TH/phase/buttons
package genesis_pad_pkg;

    typedef enum logic [1:0] {
        PAD_SMS  = 2'b00,
        PAD_3B   = 2'b01,
        PAD_6B   = 2'b10,
        PAD_NONE = 2'b11
    } pad_type_e;

    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;
    localparam int BTN_A = 4;
    localparam int BTN_B = 5;
    localparam int BTN_C = 6;
    localparam int BTN_S = 7;
    localparam int BTN_M = 8;
    localparam int BTN_X = 9;
    localparam int BTN_Y = 10;
    localparam int BTN_Z = 11;

    typedef logic [2:0] phase_t;

    localparam phase_t PHASE_SIG_LOW  = 3'd3;
    localparam phase_t PHASE_EXTRA    = 3'd4;
    localparam phase_t PHASE_SIG_HIGH = 3'd5;

    // Buttons are 1 = pressed; the port is 0 = pressed, hence the inversions.
    function automatic logic [5:0] port_mux(input pad_type_e  pad_type,
                                            input logic       th,
                                            input phase_t     phase,
                                            input logic [11:0] b);
        logic [5:0] th_high;
        logic [5:0] th_low;
        logic [5:0] word;
        th_high = ~{b[BTN_C], b[BTN_B], b[BTN_U], b[BTN_D], b[BTN_L], b[BTN_R]};
        // L/R forced low with TH=0 is how the console recognises a 3-button pad.
        th_low  = ~{b[BTN_S], b[BTN_A], b[BTN_U], b[BTN_D], 2'b11};
        word    = 6'h3F;
        case (pad_type)
            PAD_SMS: word = th_high;
            PAD_3B:  word = th ? th_high : th_low;
            PAD_6B: begin
                case (phase)
                    PHASE_SIG_LOW:  word = ~{b[BTN_S], b[BTN_A], 4'b1111};
                    PHASE_EXTRA:    word = ~{b[BTN_C], b[BTN_B], b[BTN_Z],
                                             b[BTN_Y], b[BTN_X], b[BTN_M]};
                    PHASE_SIG_HIGH: word = ~{b[BTN_S], b[BTN_A], 4'b0000};
                    default:        word = th ? th_high : th_low;
                endcase
            end
            default: word = 6'h3F;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/genpad_th_timer.sv
// TH inactivity timer for the 6-button protocol.
//   iCLK      : system clock
//   iN_RESET  : synchronous active-low reset
//   iRISE     : TH rising edge seen this cycle (restarts the count)
//   iCLEAR    : hold the counter at zero (pad not in 6-button mode / type change)
//   oEXPIRE   : combinational strobe, high on the cycle the count runs out
//               with no rise and no clear; the counter restarts on that edge
module genpad_th_timer #(
    parameter int TIMEOUT_CYCLES = 75000
) (
    input  logic iCLK,
    input  logic iN_RESET,
    input  logic iRISE,
    input  logic iCLEAR,
    output logic oEXPIRE
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          at_max;

    assign at_max  = (timer_q == TIMER_MAX);
    // A rise on the expiry cycle wins: the count restarts without a pulse.
    assign oEXPIRE = at_max && !iRISE && !iCLEAR;

    always_comb begin
        timer_d = timer_q + TW'(1);
        if (iCLEAR || iRISE || at_max) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iN_RESET) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/genesis_pad_port.sv
// Console-side emulation of one Genesis controller port.
//   iCLK        : system clock
//   iN_RESET    : synchronous active-low reset
//   iPAD_TYPE   : 00 SMS, 01 3-button, 10 6-button, 11 no pad
//   iBUTTONS    : {Z,Y,X,M,S,C,B,A,U,D,L,R}, 1 = pressed
//   iTH         : console select line, already synchronous to iCLK
//   oPORT_DATA  : registered active-low port word
//   oPHASE      : 6-button TH phase counter
//   oTIMEOUT    : one-cycle pulse when the phase is cleared by inactivity
module genesis_pad_port
    import genesis_pad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 75000
) (
    input  logic        iCLK,
    input  logic        iN_RESET,
    input  logic [1:0]  iPAD_TYPE,
    input  logic [11:0] iBUTTONS,
    input  logic        iTH,
    output logic [5:0]  oPORT_DATA,
    output logic [2:0]  oPHASE,
    output logic        oTIMEOUT
);

    pad_type_e   pad_type;
    logic [1:0]  type_q;
    logic        th_q;
    logic [11:0] btn_q;
    phase_t      phase_q;
    phase_t      phase_d;
    logic [5:0]  data_q;
    logic [5:0]  data_d;
    logic        timeout_q;

    logic        th_edge;
    logic        th_rise;
    logic        type_change;
    logic        is_6b;
    logic        timer_clear;
    logic        expire;

    assign pad_type    = pad_type_e'(iPAD_TYPE);
    assign th_edge     = iTH ^ th_q;
    assign th_rise     = iTH & ~th_q;
    assign type_change = (iPAD_TYPE != type_q);
    assign is_6b       = (pad_type == PAD_6B);
    assign timer_clear = !is_6b || type_change;

    genpad_th_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .iCLK     (iCLK),
        .iN_RESET (iN_RESET),
        .iRISE    (th_rise),
        .iCLEAR   (timer_clear),
        .oEXPIRE  (expire)
    );

    // A rise beats expiry; a timeout beats a falling edge on the same cycle.
    always_comb begin
        phase_d = phase_q;
        if (timer_clear) begin
            phase_d = '0;
        end else if (th_rise) begin
            phase_d = phase_q + 3'd1;
        end else if (expire) begin
            phase_d = '0;
        end else if (th_edge) begin
            phase_d = phase_q + 3'd1;
        end
    end

    // Uses the live TH and next phase so a TH change shows after one clock.
    assign data_d = port_mux(pad_type, iTH, phase_d, btn_q);

    // Type copy is captured even during reset so release does not look like
    // a type change.
    always_ff @(posedge iCLK) begin
        type_q <= iPAD_TYPE;
    end

    always_ff @(posedge iCLK) begin
        if (!iN_RESET) begin
            th_q      <= 1'b1;
            btn_q     <= '0;
            phase_q   <= '0;
            data_q    <= 6'h3F;
            timeout_q <= 1'b0;
        end else begin
            th_q      <= iTH;
            btn_q     <= iBUTTONS;
            phase_q   <= phase_d;
            data_q    <= data_d;
            timeout_q <= expire && !timer_clear;
        end
    end

    assign oPORT_DATA = data_q;
    assign oPHASE     = phase_q;
    assign oTIMEOUT   = timeout_q;

endmodule

// File: tb/tb_genesis_pad_port.sv
module tb_genesis_pad_port;

    logic        clk;
    logic        n_reset;
    logic [1:0]  pad_type;
    logic [11:0] buttons;
    logic        th;
    logic [5:0]  port_data;
    logic [2:0]  phase;
    logic        timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    genesis_pad_port #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .iCLK       (clk),
        .iN_RESET   (n_reset),
        .iPAD_TYPE  (pad_type),
        .iBUTTONS   (buttons),
        .iTH        (th),
        .oPORT_DATA (port_data),
        .oPHASE     (phase),
        .oTIMEOUT   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
    endtask

    // Hold inputs for n cycles and report whether any timeout pulse appeared.
    task automatic hold(input int n, output logic saw_pulse);
        saw_pulse = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (timeout) saw_pulse = 1'b1;
        end
    endtask

    logic [5:0] exp_data [8];
    logic       pulse;

    initial begin
        n_reset  = 1'b0;
        pad_type = 2'b01;
        buttons  = 12'h000;
        th       = 1'b1;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            pad_type = 2'($urandom_range(0, 3));
            buttons  = 12'($urandom);
            th       = 1'($urandom);
            tick();
            check("rst_data", 32'(port_data), 32'h3F);
            check("rst_phase", 32'(phase), 32'd0);
            check("rst_timeout", 32'(timeout), 32'd0);
        end
        pad_type = 2'b01;
        buttons  = 12'h090;
        th       = 1'b0;
        n_reset  = 1'b1;
        tick();
        check("rel_first", 32'(port_data), 32'b111100);
        tick();
        check("rel_second", 32'(port_data), 32'b001100);

        // 3-button, S+A
        th = 1'b1;
        tick();
        check("3b_th1", 32'(port_data), 32'h3F);
        th = 1'b0;
        tick();
        check("3b_th0", 32'(port_data), 32'b001100);
        check("3b_phase", 32'(phase), 32'd0);
        th = 1'b1;
        tick();
        check("3b_th1_again", 32'(port_data), 32'h3F);
        check("3b_phase_again", 32'(phase), 32'd0);
        // Button latency is two clocks
        buttons = 12'h001;
        tick();
        check("btn_lat1", 32'(port_data), 32'h3F);
        tick();
        check("btn_lat2", 32'(port_data), 32'b111110);
        // Full D-pad is passed through
        buttons = 12'h00F;
        tick();
        tick();
        check("3b_dpad_all", 32'(port_data), 32'b110000);

        // 6-button, X pressed, toggle every 10 cycles
        pad_type = 2'b10;
        buttons  = 12'h200;
        th       = 1'b1;
        do_reset();
        tick();
        tick();
        check("6b_ph0", 32'(port_data), 32'h3F);
        check("6b_ph0_phase", 32'(phase), 32'd0);
        exp_data[0] = 6'h3F;
        exp_data[1] = 6'b111100;
        exp_data[2] = 6'h3F;
        exp_data[3] = 6'b110000;
        exp_data[4] = 6'b111101;
        exp_data[5] = 6'h3F;
        exp_data[6] = 6'h3F;
        exp_data[7] = 6'b111100;
        for (int k = 1; k <= 8; k++) begin
            th = ~th;
            tick();
            check($sformatf("6b_phase%0d", k), 32'(phase), 32'(k % 8));
            check($sformatf("6b_data%0d", k), 32'(port_data), 32'(exp_data[k % 8]));
            hold(9, pulse);
            check($sformatf("6b_held%0d", k), 32'(port_data), 32'(exp_data[k % 8]));
            check($sformatf("6b_nopulse%0d", k), 32'(pulse), 32'd0);
        end

        // Timeout from phase 2
        buttons = 12'h000;
        th      = 1'b1;
        do_reset();
        th = 1'b0; tick();
        th = 1'b1; tick();
        check("to_phase2", 32'(phase), 32'd2);
        hold(99, pulse);
        check("to_early_pulse", 32'(pulse), 32'd0);
        check("to_phase_before", 32'(phase), 32'd2);
        tick();
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_phase_cleared", 32'(phase), 32'd0);
        tick();
        check("to_pulse_once", 32'(timeout), 32'd0);
        th = 1'b0;
        tick();
        check("to_next_phase", 32'(phase), 32'd1);
        check("to_next_data", 32'(port_data), 32'b111100);

        // Rise on the expiry cycle
        th = 1'b1;
        do_reset();
        th = 1'b0; tick();
        th = 1'b1; tick();
        th = 1'b0; tick();
        hold(98, pulse);
        check("co_no_pulse_before", 32'(pulse), 32'd0);
        check("co_phase3", 32'(phase), 32'd3);
        th = 1'b1;
        tick();
        check("co_phase4", 32'(phase), 32'd4);
        check("co_no_pulse", 32'(timeout), 32'd0);
        hold(99, pulse);
        check("co_timer_restart", 32'(pulse), 32'd0);
        tick();
        check("co_later_pulse", 32'(timeout), 32'd1);

        // Type switch 6-button -> SMS at phase 4, C pressed
        buttons = 12'h040;
        th      = 1'b1;
        do_reset();
        tick();
        tick();
        th = 1'b0; tick();
        th = 1'b1; tick();
        th = 1'b0; tick();
        th = 1'b1; tick();
        check("sw_phase4", 32'(phase), 32'd4);
        check("sw_data4", 32'(port_data), 32'b011111);
        pad_type = 2'b00;
        tick();
        check("sw_phase0", 32'(phase), 32'd0);
        check("sw_sms_data", 32'(port_data), 32'b011111);
        for (int k = 0; k < 4; k++) begin
            th = ~th;
            tick();
            check($sformatf("sms_th_phase%0d", k), 32'(phase), 32'd0);
            check($sformatf("sms_th_data%0d", k), 32'(port_data), 32'b011111);
        end
        // Reset mid-phase
        pad_type = 2'b10;
        th       = 1'b1;
        tick();
        th = 1'b0; tick();
        th = 1'b1; tick();
        check("mid_phase2", 32'(phase), 32'd2);
        n_reset = 1'b0;
        tick();
        check("mid_rst_data", 32'(port_data), 32'h3F);
        check("mid_rst_phase", 32'(phase), 32'd0);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        n_reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
